// File: rtl/hsync_pkg.sv
// Shared constants, defaults and FSM encoding for the horizontal-sync monitor.
// Imported by the interface, the edge detector and the monitor top.
package hsync_pkg;

    localparam int COUNT_W = 11;
    localparam int MATCH_W = 3;

    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [MATCH_W-1:0] match_t;

    localparam count_t CNT_MAX = count_t'(2047);

    localparam int H_TOTAL_DEF    = 800;
    localparam int H_SYNC_DEF     = 96;
    localparam int LOCK_LINES_DEF = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Position of the current sample: the registered count plus one, modulo 2^11.
    function automatic count_t count_inc(input count_t value);
        return value + count_t'(1);
    endfunction

endpackage

// File: rtl/hsync_monitor_if.sv
// Line-timing bus between a video source and the sync monitor.
// The source drives hSync/hDisp; the monitor returns lock status and measurements.
interface hsync_monitor_if;
    import hsync_pkg::*;

    logic   hSync;
    logic   hDisp;
    logic   locked;
    logic   lineStrobe;
    logic   syncErr;
    count_t xPos;
    count_t periodMeas;
    count_t syncMeas;
    count_t dispStart;
    count_t dispWidth;

    modport master (
        output hSync,
        output hDisp,
        input  locked,
        input  lineStrobe,
        input  syncErr,
        input  xPos,
        input  periodMeas,
        input  syncMeas,
        input  dispStart,
        input  dispWidth
    );

    modport slave (
        input  hSync,
        input  hDisp,
        output locked,
        output lineStrobe,
        output syncErr,
        output xPos,
        output periodMeas,
        output syncMeas,
        output dispStart,
        output dispWidth
    );

endinterface

// File: rtl/edge_detect.sv
// One-bit previous-sample register with combinational rise/fall outputs.
// RST_VAL sets the previous sample held during reset.
module edge_detect
    import hsync_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= RST_VAL;
        end else begin
            prev <= d;
        end
    end

    assign rise = ~prev &  d;
    assign fall =  prev & ~d;

endmodule

// File: rtl/hsync_monitor.sv
// Horizontal sync monitor: recovers pixel position, measures line timing and
// locks once LOCK_LINES consecutive lines match H_TOTAL / H_SYNC.
module hsync_monitor
    import hsync_pkg::*;
#(
    parameter int H_TOTAL    = H_TOTAL_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int LOCK_LINES = LOCK_LINES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    hsync_monitor_if.slave bus
);

    localparam count_t H_TOTAL_C    = count_t'(H_TOTAL);
    localparam count_t H_SYNC_C     = count_t'(H_SYNC);
    localparam match_t LOCK_LINES_C = match_t'(LOCK_LINES);

    logic   sync_rise;
    logic   sync_fall;
    logic   disp_rise;
    logic   disp_fall;

    count_t cnt;
    count_t cnt_inc;
    count_t sync_meas;
    count_t disp_start;
    count_t disp_width;
    count_t period_meas;

    state_t state;
    state_t state_next;
    match_t match_cnt;
    match_t match_next;
    logic   rise_seen;
    logic   rise_seen_next;
    logic   line_strobe;
    logic   strobe_next;
    logic   sync_err;
    logic   err_next;
    logic   period_load;
    logic   line_good;

    // The sync previous sample idles high so a line already in sync at reset release is caught.
    edge_detect #(.RST_VAL(1'b1)) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.hSync),
        .rise (sync_rise),
        .fall (sync_fall)
    );

    edge_detect #(.RST_VAL(1'b0)) u_disp_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.hDisp),
        .rise (disp_rise),
        .fall (disp_fall)
    );

    assign cnt_inc = count_inc(cnt);

    // NOTE: every register, measurement included, is reset so outputs read 0 during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sync_meas  <= '0;
            disp_start <= '0;
            disp_width <= '0;
        end else begin
            if (sync_fall) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt_inc;
            end

            if (sync_rise) begin
                sync_meas <= cnt_inc;
            end

            if (disp_rise) begin
                disp_start <= cnt_inc;
            end

            if (disp_fall) begin
                disp_width <= cnt_inc - disp_start;
            end
        end
    end

    assign line_good = (cnt_inc == H_TOTAL_C) && rise_seen && (sync_meas == H_SYNC_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            match_cnt   <= '0;
            rise_seen   <= 1'b0;
            line_strobe <= 1'b0;
            sync_err    <= 1'b0;
            period_meas <= '0;
        end else begin
            state       <= state_next;
            match_cnt   <= match_next;
            rise_seen   <= rise_seen_next;
            line_strobe <= strobe_next;
            sync_err    <= err_next;
            if (period_load) begin
                period_meas <= cnt_inc;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next     = state;
        match_next     = match_cnt;
        rise_seen_next = rise_seen;
        strobe_next    = 1'b0;
        err_next       = 1'b0;
        period_load    = 1'b0;

        if (sync_rise) begin
            rise_seen_next = 1'b1;
        end

        case (state)
            SEARCH: begin
                if (sync_fall) begin
                    state_next     = TRACK;
                    match_next     = '0;
                    rise_seen_next = 1'b0;
                end
            end

            TRACK, LOCKED: begin
                // A saturated counter means the line already overran; it wins over a late fall.
                if (cnt == CNT_MAX) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end else if (sync_fall) begin
                    strobe_next    = 1'b1;
                    period_load    = 1'b1;
                    rise_seen_next = 1'b0;
                    if (line_good) begin
                        if (state == TRACK) begin
                            match_next = match_cnt + match_t'(1);
                            if (match_next == LOCK_LINES_C) begin
                                state_next = LOCKED;
                            end
                        end
                    end else begin
                        state_next = TRACK;
                        match_next = '0;
                        err_next   = 1'b1;
                    end
                end
            end

            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    assign bus.locked     = (state == LOCKED);
    assign bus.lineStrobe = line_strobe;
    assign bus.syncErr    = sync_err;
    assign bus.xPos       = cnt;
    assign bus.periodMeas = period_meas;
    assign bus.syncMeas   = sync_meas;
    assign bus.dispStart  = disp_start;
    assign bus.dispWidth  = disp_width;

endmodule

// File: tb/tb_hsync_monitor.sv
// Directed bench for hsync_monitor: table of whole lines plus hand-written
// sequences for timeout and mid-line reset.
module tb_hsync_monitor;
    import hsync_pkg::*;

    // One generated line. Expectations on strobe/err/locked/period refer to the cycle
    // after this line's opening fall (which closes the previous line); sync/dstart/dwidth
    // are the measurements taken during this line.
    typedef struct packed {
        int   period;
        int   sync_w;
        int   ds;
        int   de;
        logic exp_strobe;
        logic exp_err;
        logic exp_locked;
        int   exp_period;
        int   exp_sync;
        int   exp_dstart;
        int   exp_dwidth;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hsync_monitor_if bus();

    hsync_monitor #(
        .H_TOTAL    (800),
        .H_SYNC     (96),
        .LOCK_LINES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".locked"},     32'(bus.locked),     0);
        check({tag, ".lineStrobe"}, 32'(bus.lineStrobe), 0);
        check({tag, ".syncErr"},    32'(bus.syncErr),    0);
        check({tag, ".xPos"},       32'(bus.xPos),       0);
        check({tag, ".periodMeas"}, 32'(bus.periodMeas), 0);
        check({tag, ".syncMeas"},   32'(bus.syncMeas),   0);
        check({tag, ".dispStart"},  32'(bus.dispStart),  0);
        check({tag, ".dispWidth"},  32'(bus.dispWidth),  0);
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        logic   s0 = 1'b0;
        logic   e0 = 1'b0;
        logic   l0 = 1'b0;
        logic   l_or = 1'b0;
        count_t x0 = '1;
        count_t p0 = '1;
        int     extra_s = 0;
        int     extra_e = 0;
        for (int g = 0; g < v.period; g++) begin
            bus.hSync = (g < v.sync_w) ? 1'b0 : 1'b1;
            bus.hDisp = (g >= v.ds && g < v.de) ? 1'b1 : 1'b0;
            tick();
            if (g == 0) begin
                s0 = bus.lineStrobe;
                e0 = bus.syncErr;
                l0 = bus.locked;
                x0 = bus.xPos;
                p0 = bus.periodMeas;
            end else begin
                extra_s += int'(bus.lineStrobe);
                extra_e += int'(bus.syncErr);
                l_or     = l_or | bus.locked;
            end
        end
        check({tag, ".strobe"},      32'(s0),            32'(v.exp_strobe));
        check({tag, ".err"},         32'(e0),            32'(v.exp_err));
        check({tag, ".locked"},      32'(l0),            32'(v.exp_locked));
        check({tag, ".xpos0"},       32'(x0),            0);
        check({tag, ".period"},      32'(p0),            v.exp_period);
        check({tag, ".locked_line"}, 32'(l_or),          32'(v.exp_locked));
        check({tag, ".extra_strb"},  extra_s,            0);
        check({tag, ".extra_err"},   extra_e,            0);
        check({tag, ".sync"},        32'(bus.syncMeas),  v.exp_sync);
        check({tag, ".dstart"},      32'(bus.dispStart), v.exp_dstart);
        check({tag, ".dwidth"},      32'(bus.dispWidth), v.exp_dwidth);
    endtask

    initial begin
        int err_cnt;
        int err_at;
        int strobe_cnt;

        //          period sync  ds   de  strb err  lock period sync dstart dwidth
        vecs[0]  = '{800,  96, 145, 784, 1'b0, 1'b0, 1'b0,   0,  96, 145, 639};
        vecs[1]  = '{800,  96, 145, 784, 1'b1, 1'b0, 1'b0, 800,  96, 145, 639};
        vecs[2]  = '{800,  96, 145, 784, 1'b1, 1'b0, 1'b1, 800,  96, 145, 639};
        vecs[3]  = '{801,  96, 145, 784, 1'b1, 1'b0, 1'b1, 800,  96, 145, 639};
        vecs[4]  = '{800,  96, 145, 784, 1'b1, 1'b1, 1'b0, 801,  96, 145, 639};
        vecs[5]  = '{800,  96, 145, 784, 1'b1, 1'b0, 1'b0, 800,  96, 145, 639};
        vecs[6]  = '{800,  96, 145, 784, 1'b1, 1'b0, 1'b1, 800,  96, 145, 639};
        vecs[7]  = '{800,  95, 145, 784, 1'b1, 1'b0, 1'b1, 800,  95, 145, 639};
        vecs[8]  = '{800,  95, 145, 784, 1'b1, 1'b1, 1'b0, 800,  95, 145, 639};
        vecs[9]  = '{800,  95, 145, 784, 1'b1, 1'b1, 1'b0, 800,  95, 145, 639};
        vecs[10] = '{800,  95, 145, 784, 1'b1, 1'b1, 1'b0, 800,  95, 145, 639};
        vecs[11] = '{800,  96, 145, 784, 1'b1, 1'b1, 1'b0, 800,  96, 145, 639};
        vecs[12] = '{800,  96, 145, 784, 1'b1, 1'b0, 1'b0, 800,  96, 145, 639};
        vecs[13] = '{800,  96, 145, 784, 1'b1, 1'b0, 1'b1, 800,  96, 145, 639};

        // Reset with the source idle.
        rst       = 1'b1;
        bus.hSync = 1'b1;
        bus.hDisp = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) tick();
        check("idle.locked", 32'(bus.locked), 0);
        check("idle.strobe", 32'(bus.lineStrobe), 0);

        // Lock, 801-cycle line, relock, sync-width-95 lines, relock.
        for (int i = 0; i < 14; i++) begin
            apply_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Locked, then the sync stays high after one pulse until the counter saturates.
        err_cnt    = 0;
        err_at     = -1;
        strobe_cnt = 0;
        bus.hDisp  = 1'b0;
        for (int g = 0; g < 2100; g++) begin
            bus.hSync = (g < 96) ? 1'b0 : 1'b1;
            tick();
            if (g == 0) begin
                check("to.close_strobe", 32'(bus.lineStrobe), 1);
            end else begin
                strobe_cnt += int'(bus.lineStrobe);
                if (bus.syncErr) begin
                    err_cnt++;
                    if (err_at < 0) err_at = g;
                end
            end
            if (g == 2047) check("to.locked_before", 32'(bus.locked), 1);
        end
        check("to.err_count",  err_cnt, 1);
        check("to.err_cycle",  err_at, 2048);
        check("to.strobes",    strobe_cnt, 0);
        check("to.locked",     32'(bus.locked), 0);
        check("to.xpos_sat",   32'(bus.xPos), 2047);

        // First fall after the timeout must be treated as a fresh search (no strobe).
        apply_vec("rl0", '{800, 96, 145, 784, 1'b0, 1'b0, 1'b0, 800, 96, 145, 639});
        apply_vec("rl1", '{800, 96, 145, 784, 1'b1, 1'b0, 1'b0, 800, 96, 145, 639});
        apply_vec("rl2", '{800, 96, 145, 784, 1'b1, 1'b0, 1'b1, 800, 96, 145, 639});

        // Mid-line reset while locked.
        for (int g = 0; g < 400; g++) begin
            bus.hSync = (g < 96) ? 1'b0 : 1'b1;
            bus.hDisp = (g >= 145 && g < 784) ? 1'b1 : 1'b0;
            tick();
        end
        check("mr.locked_before", 32'(bus.locked), 1);
        rst       = 1'b1;
        bus.hSync = 1'b1;
        tick();
        check_all_zero("mr");
        rst        = 1'b0;
        err_cnt    = 0;
        strobe_cnt = 0;
        for (int g = 401; g < 800; g++) begin
            bus.hSync = 1'b1;
            bus.hDisp = (g >= 145 && g < 784) ? 1'b1 : 1'b0;
            tick();
            strobe_cnt += int'(bus.lineStrobe);
            err_cnt    += int'(bus.syncErr);
        end
        check("mr.strobes", strobe_cnt, 0);
        check("mr.errs",    err_cnt, 0);
        check("mr.locked",  32'(bus.locked), 0);
        apply_vec("mr0", '{800, 96, 145, 784, 1'b0, 1'b0, 1'b0,   0, 96, 145, 639});
        apply_vec("mr1", '{800, 96, 145, 784, 1'b1, 1'b0, 1'b0, 800, 96, 145, 639});
        apply_vec("mr2", '{800, 96, 145, 784, 1'b1, 1'b0, 1'b1, 800, 96, 145, 639});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
